// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by seq_alu and its users
package alu_pkg;
  localparam int ALU_OP_W = 4;
  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_NEG   = 4'h2,
    OP_NOT   = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_MUL   = 4'h6,
    OP_DIV   = 4'h7,
    OP_SHR   = 4'h8,
    OP_SHRA  = 4'h9,
    OP_SHL   = 4'hA,
    OP_ROR   = 4'hB,
    OP_ROL   = 4'hC,
    OP_INCPC = 4'hD,
    OP_BR    = 4'hE,
    OP_RSVD  = 4'hF
  } alu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN_MUL, S_RUN_DIV, S_FIX_DIV} state_t;
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/done request and result bus between the control unit and seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic                         start;
  logic [alu_pkg::ALU_OP_W-1:0] op;
  logic [WIDTH-1:0]             y_in;
  logic [WIDTH-1:0]             b_in;
  logic [2*WIDTH-1:0]           C;
  logic                         busy;
  logic                         done;
  logic                         div_by_zero;
  modport master (output start, op, y_in, b_in, input C, busy, done, div_by_zero);
  modport slave (input start, op, y_in, b_in, output C, busy, done, div_by_zero);
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: shared iterative radix-4 Booth multiplier / non-restoring divider (divider only with SEQ_ALU_DIV_EN)
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH+1:0] acc, acc_src, acc_nxt, bm, badd, bsum, bacc;
  logic [WIDTH-1:0] q, q_src, q_nxt, m, m_src, bq;
  logic qm1, qm1_src;
  logic [CW-1:0] cnt, cnt_ld;
  assign acc_src = load ? '0 : acc;
  assign qm1_src = load ? 1'b0 : qm1;
  assign bm = {{2{m_src[WIDTH-1]}}, m_src};
  // Booth radix-4 digit selects 0, +-M or +-2M from the next multiplier pair
  always_comb begin
    case ({q_src[1:0], qm1_src})
      3'b001, 3'b010: badd = bm;
      3'b011:         badd = bm << 1;
      3'b100:         badd = -(bm << 1);
      3'b101, 3'b110: badd = -bm;
      default:        badd = '0;
    endcase
  end
  assign bsum = acc_src + badd;
  assign bacc = {{2{bsum[WIDTH+1]}}, bsum[WIDTH+1:2]};
  assign bq = {bsum[1:0], q_src[WIDTH-1:2]};
  assign last = cnt == CW'(1);
`ifdef SEQ_ALU_DIV_EN
  logic mode, mode_src, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, rem_mag, rem, quo;
  logic [WIDTH:0] dsh, dr;
  assign mode_src = load ? is_div : mode;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign m_src = load ? (is_div ? b_mag : a) : m;
  assign q_src = load ? (is_div ? a_mag : b) : q;
  assign dsh = {acc_src[WIDTH-1:0], q_src[WIDTH-1]};
  assign dr = acc_src[WIDTH] ? dsh + {1'b0, m_src} : dsh - {1'b0, m_src};
  assign acc_nxt = mode_src ? {dr[WIDTH], dr} : bacc;
  assign q_nxt = mode_src ? {q_src[WIDTH-2:0], ~dr[WIDTH]} : bq;
  assign cnt_ld = is_div ? CW'(WIDTH - 1) : CW'(WIDTH / 2 - 1);
  assign rem_mag = acc[WIDTH] ? acc[WIDTH-1:0] + m : acc[WIDTH-1:0];
  assign quo = (a_neg ^ b_neg) ? -q : q;
  assign rem = a_neg ? -rem_mag : rem_mag;
  assign result = fix ? {rem, quo} : {bacc[WIDTH-1:0], bq};
  // operation mode and operand signs for the final sign correction
  always_ff @(posedge clock)
    if (clear) {mode, a_neg, b_neg} <= '0;
    else if (load) {mode, a_neg, b_neg} <= {is_div, a[WIDTH-1], b[WIDTH-1]};
`else
  logic unused_div;
  assign unused_div = is_div ^ fix;
  assign m_src = load ? a : m;
  assign q_src = load ? b : q;
  assign acc_nxt = bacc;
  assign q_nxt = bq;
  assign cnt_ld = CW'(WIDTH / 2 - 1);
  assign result = {bacc[WIDTH-1:0], bq};
`endif
  // iteration registers; load performs the first step from the raw operands
  always_ff @(posedge clock)
    if (clear) begin
      acc <= '0;
      q <= '0;
      m <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (load || step) begin
      acc <= acc_nxt;
      q <= q_nxt;
      m <= m_src;
      qm1 <= q_src[1];
      cnt <= load ? cnt_ld : cnt - CW'(1);
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: start/done multi-cycle ALU; define SEQ_ALU_DIV_EN to compile in the divider
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clock,
  input logic      clear,
  seq_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  state_t state, state_nxt;
  alu_op_t op;
  logic load, step, fix, is_div, last, done_nxt, busy_nxt, dz_nxt, busy_q, done_q, dz_q;
  logic [WIDTH-1:0] y, b, single;
  logic [SW-1:0] amt;
  logic [2*WIDTH-1:0] mres, c_nxt, c_q, ror_w, rol_w;
  assign y = bus.y_in;
  assign b = bus.b_in;
  assign op = alu_op_t'(bus.op);
  assign amt = b[SW-1:0];
  assign ror_w = {y, y} >> amt;
  assign rol_w = {y, y} << amt;
`ifdef SEQ_ALU_DIV_EN
  assign is_div = op == OP_DIV;
`else
  assign is_div = 1'b0;
`endif
  assign bus.C = c_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div_by_zero = dz_q;
  seq_alu_muldiv #(.WIDTH(WIDTH)) u_md (
    .clock(clock), .clear(clear), .load(load), .step(step), .fix(fix),
    .is_div(is_div), .a(y), .b(b), .last(last), .result(mres)
  );
  // single-cycle results; MUL, DIV and the reserved code yield zero here
  always_comb begin
    case (op)
      OP_AND:   single = y & b;
      OP_OR:    single = y | b;
      OP_NEG:   single = -y;
      OP_NOT:   single = ~y;
      OP_ADD:   single = y + b;
      OP_SUB:   single = y - b;
      OP_SHR:   single = y >> amt;
      OP_SHRA:  single = $signed(y) >>> amt;
      OP_SHL:   single = y << amt;
      OP_ROR:   single = ror_w[WIDTH-1:0];
      OP_ROL:   single = rol_w[2*WIDTH-1:WIDTH];
      OP_INCPC: single = b + WIDTH'(1);
      OP_BR:    single = y + b;
      default:  single = '0;
    endcase
  end
  // next state, datapath controls and next output values
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    step = 1'b0;
    fix = 1'b0;
    done_nxt = 1'b0;
    dz_nxt = 1'b0;
    busy_nxt = busy_q;
    c_nxt = '0;
    case (state)
      S_IDLE:
        if (bus.start) begin
          if (op == OP_MUL) begin
            load = 1'b1;
            busy_nxt = 1'b1;
            state_nxt = S_RUN_MUL;
          end
`ifdef SEQ_ALU_DIV_EN
          else if (op == OP_DIV && b == '0) begin
            done_nxt = 1'b1;
            dz_nxt = 1'b1;
            c_nxt = {y, {WIDTH{1'b1}}};
          end else if (op == OP_DIV) begin
            load = 1'b1;
            busy_nxt = 1'b1;
            state_nxt = S_RUN_DIV;
          end
`endif
          else begin
            done_nxt = 1'b1;
            c_nxt = {{WIDTH{1'b0}}, single};
          end
        end
      S_RUN_MUL: begin
        step = 1'b1;
        if (last) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          c_nxt = mres;
          state_nxt = S_IDLE;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_RUN_DIV: begin
        step = 1'b1;
        if (last) state_nxt = S_FIX_DIV;
      end
      S_FIX_DIV: begin
        fix = 1'b1;
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
        c_nxt = mres;
        state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end
  // state and output registers; C only changes on done
  always_ff @(posedge clock)
    if (clear) begin
      state <= S_IDLE;
      c_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state <= state_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      dz_q <= dz_nxt;
      if (done_nxt) c_q <= c_nxt;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu driven by directed vectors
module tb_seq_alu;
  import alu_pkg::*;
  localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  typedef struct {
    logic [2*W-1:0] c;
    logic           dz;
    int             at;
    string          name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clock(clk), .clear(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(string n, logic [2*W-1:0] act, logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endfunction
  always @(negedge clk)
    if (bus.done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
      else begin
        e = sb.pop_front();
        chk({e.name, "_c"}, bus.C, e.c);
        chk({e.name, "_dz"}, 64'(bus.div_by_zero), 64'(e.dz));
        chk({e.name, "_lat"}, 64'(cyc), 64'(e.at));
        chk({e.name, "_busy"}, 64'(bus.busy), 64'd0);
      end
    end
  task automatic issue(string n, alu_op_t op, logic [W-1:0] y, logic [W-1:0] b,
                       logic [2*W-1:0] c, logic dz, int lat);
    exp_t e;
    bus.start = 1'b1;
    bus.op = op;
    bus.y_in = y;
    bus.b_in = b;
    e.c = c;
    e.dz = dz;
    e.at = cyc + lat;
    e.name = n;
    sb.push_back(e);
    @(negedge clk);
  endtask
  task automatic drain();
    bus.start = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask
  initial begin
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.y_in = 32'd1;
    bus.b_in = 32'd1;
    repeat (2) @(negedge clk);
    chk("rst_c", bus.C, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_start_dropped", 64'(bus.done), 64'd0);
    issue("add", OP_ADD, 32'h7FFF_FFFF, 32'h1, 64'h8000_0000, 1'b0, 1);
    issue("rol", OP_ROL, 32'h8000_0001, 32'd33, 64'h3, 1'b0, 1);
    issue("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 64'h00F0_1234, 1'b0, 1);
    issue("or", OP_OR, 32'h0000_00F0, 32'h0000_000F, 64'hFF, 1'b0, 1);
    issue("neg", OP_NEG, 32'h1, 32'h0, 64'hFFFF_FFFF, 1'b0, 1);
    issue("not", OP_NOT, 32'h0F0F_0F0F, 32'h0, 64'hF0F0_F0F0, 1'b0, 1);
    issue("shr", OP_SHR, 32'h8000_0000, 32'd31, 64'h1, 1'b0, 1);
    issue("shra", OP_SHRA, 32'h8000_0000, 32'h24, 64'hF800_0000, 1'b0, 1);
    issue("shl32", OP_SHL, 32'h1, 32'd32, 64'h1, 1'b0, 1);
    issue("ror", OP_ROR, 32'h1, 32'd1, 64'h8000_0000, 1'b0, 1);
    issue("incpc", OP_INCPC, 32'd123, 32'hFFFF_FFFF, 64'h0, 1'b0, 1);
    issue("branch", OP_BR, 32'h100, 32'h20, 64'h120, 1'b0, 1);
    issue("rsvd", OP_RSVD, 32'd5, 32'd6, 64'h0, 1'b0, 1);
    drain();
    issue("div", OP_DIV, 32'hFFFF_FFEF, 32'd5, DIV ? 64'hFFFF_FFFE_FFFF_FFFD : 64'h0, 1'b0, DIV ? 33 : 1);
    drain();
    issue("div0", OP_DIV, 32'd100, 32'd0, DIV ? 64'h0000_0064_FFFF_FFFF : 64'h0, DIV, 1);
    drain();
    issue("divmn", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV ? 64'h8000_0000 : 64'h0, 1'b0, DIV ? 33 : 1);
    drain();
    issue("div7", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV ? 64'h0000_0001_FFFF_FFFD : 64'h0, 1'b0, DIV ? 33 : 1);
    drain();
    issue("mul", OP_MUL, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 16);
    chk("mul_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.y_in = 32'd9;
    bus.b_in = 32'd9;
    @(negedge clk);
    drain();
    issue("mulmn", OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 16);
    drain();
    repeat (3) @(negedge clk);
    chk("hold_c", bus.C, 64'h4000_0000_0000_0000);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.y_in = 32'd5;
    bus.b_in = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("clr_c", bus.C, 64'd0);
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_done", 64'(bus.done), 64'd0);
    repeat (20) @(negedge clk);
    chk("clr_idle_busy", 64'(bus.busy), 64'd0);
    issue("sub", OP_SUB, 32'd3, 32'd5, 64'hFFFF_FFFE, 1'b0, 1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the datapath. It replaces the single-cycle combinational ALU with a start/done-handshaked unit. Logic, shift, rotate, add and PC operations complete in one clock. Signed multiply runs as an iterative radix-4 Booth unit and signed divide as an iterative non-restoring unit. It sits between the Y register / bus mux and the Z (Zhigh/Zlow) register pair; the control unit holds the step until `done`.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 8.
- `clock` in 1: single clock, rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 4: operation code (alu_pkg encoding).
- `y_in` in WIDTH: operand A (Y register).
- `b_in` in WIDTH: operand B (BusMuxOut).
- `C` out 2·WIDTH: result; upper half = MUL high / DIV remainder, else 0.
- `busy` out 1: high while a multi-cycle op is in flight.
- `done` out 1: one-cycle pulse, `C` valid from this cycle.
- `div_by_zero` out 1: qualified by `done`; high for DIV with `b_in`=0.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NEG(y), 3 NOT(y), 4 ADD, 5 SUB (y−b), 6 MUL, 7 DIV, 8 SHR, 9 SHRA, A SHL, B ROR, C ROL, D INCPC (b+1), E BRANCH (y+b), F reserved.
  - Op F gives C=0.
- Shift and rotate amount = `b_in[$clog2(WIDTH)-1:0]`, i.e. modulo WIDTH.
- Add/sub wrap modulo 2^WIDTH; no flags.
- Operands are captured on the edge that accepts `start`. Input changes afterwards have no effect.
- FSM states:
  - IDLE: accepts `start`. Single-cycle ops and F write `C`, pulse `done` and stay in IDLE. MUL goes to RUN_MUL, DIV to RUN_DIV. DIV with b=0 stays in IDLE.
  - RUN_MUL: WIDTH/2 Booth iterations counted by a down-counter. `C` and `done` are written on the last iteration; then IDLE.
  - RUN_DIV: WIDTH iterations on operand magnitudes; then FIX_DIV.
  - FIX_DIV: final remainder restore and sign correction. Quotient truncates toward zero; remainder takes the sign of the dividend. Writes `C`, pulses `done`; then IDLE.
- MUL: `C` = full signed 2·WIDTH product.
- DIV: `C` = {remainder, quotient}.
- DIV by zero: quotient = all ones, remainder = `y_in`, `div_by_zero`=1.
- DIV of most-negative by −1: quotient = most-negative (wraps), remainder 0.
- `start` while `busy` is ignored and not queued.
- `C` holds its value until the next `done`.

## Timing
- Reset values: `C`=0, `busy`=0, `done`=0, `div_by_zero`=0, FSM=IDLE, counter=0.
- Latency, counted in edges from the edge that samples `start` to the edge that raises `done`:
  - 1 for single-cycle ops, op F and divide-by-zero;
  - WIDTH/2 for MUL;
  - WIDTH+1 for DIV.
- `busy` rises on the accepting edge for MUL/DIV and falls on the edge that raises `done`.
- Back-to-back: `start` may be high in the same cycle as `done`; it is accepted, so one op completes per cycle for single-cycle ops.
- `clear` mid-operation wins over everything: return to IDLE, all outputs to reset values, partial result discarded, no `done`.
- `clear` and `start` in the same cycle: `start` is dropped.

## Configuration
- `SEQ_ALU_DIV_EN` defined: divider, RUN_DIV and FIX_DIV are compiled in; behaviour as above.
- Not defined: DIV is treated as op F: C=0, `done` after 1 edge, `div_by_zero` always 0, no divider logic.

## Structure
- `alu_pkg` holds:
  - `alu_op_t` opcode enum (4 bits, encoding above);
  - FSM state enum;
  - `ALU_OP_W = 4`.
- Sub-module `seq_alu_muldiv`: shared iterative datapath with the Booth and non-restoring step logic, iteration counter and sign fix-up, with load/step/fix controls.
- Top-level `seq_alu` holds the FSM, the single-cycle combinational ops, output registers and the handshake.

## Test plan
All values with WIDTH=32.
- Reset: assert `clear` for 2 cycles with `start`=1 -> C=0, busy=0, done=0, nothing accepted.
- ADD 0x7FFFFFFF+1 -> done after 1 edge, C=0x0000_0000_8000_0000. Then back-to-back ROL y=0x80000001, b=33 -> next cycle C=0x0000_0000_0000_0003.
- MUL y=−7, b=6 -> busy for 16 edges, done on the 16th, C=0xFFFF_FFFF_FFFF_FFD6. A `start` pulse mid-op is ignored.
- DIV y=−17, b=5 -> done on edge 33, C=0xFFFF_FFFE_FFFF_FFFD, div_by_zero=0.
- DIV y=100, b=0 -> done after 1 edge, C=0x0000_0064_FFFF_FFFF, div_by_zero=1. Without `SEQ_ALU_DIV_EN`: C=0, div_by_zero=0.
- MUL start, then `clear` at iteration 5 -> no done, C=0, IDLE. A following SUB 3−5 gives C=0x0000_0000_FFFF_FFFE.
